data_mem_responder: RTL and testbench

//   Responder end of the core's load/store memory interface: accepts one request at a

---
 rtl/data_mem_responder.sv | 157 +++++++++++++++
 tb/tb_data_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, answered after
// WAIT_CYCLES wait states. Little-endian byte/half/word access with load extension.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_uns,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;

  logic                  l_we, l_uns;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic [1:0]            l_size;

  logic                  c_we, c_uns;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [1:0]            c_size;

  logic                  accept, commit, c_err;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] word, wd, ld;
  logic [3:0]            be;
  logic [7:0]            lb;
  logic [15:0]           lh;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && (state == IDLE);
  // Zero-wait commits on the accept edge; otherwise on the last BUSY edge.
  assign commit    = (accept && (WAIT_CYCLES == 0)) || ((state == BUSY) && (cnt == CW'(1)));

  // Commit source: live inputs on the accept edge (zero-wait), latched copy otherwise.
  always_comb begin
    c_we    = l_we;
    c_addr  = l_addr;
    c_wdata = l_wdata;
    c_size  = l_size;
    c_uns   = l_uns;
    if (state == IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_size  = req_size;
      c_uns   = req_uns;
    end
  end

  // Fault detection, byte enables, lane replication and load extension.
  always_comb begin
    c_err = (c_size == 2'b11) ||
            ((c_size == 2'b01) && c_addr[0]) ||
            ((c_size == 2'b10) && (c_addr[1:0] != 2'b00)) ||
            ({2'b00, c_addr[ADDR_WIDTH-1:2]} >= LIMIT);
    idx  = c_addr[IW+1:2];
    word = mem[idx];
    lb   = word[{c_addr[1:0], 3'b000} +: 8];
    lh   = word[{c_addr[1], 4'b0000} +: 16];
    be   = 4'hf;
    wd   = c_wdata;
    ld   = word;
    case (c_size)
      2'b00: begin
        be = 4'b0001 << c_addr[1:0];
        wd = {4{c_wdata[7:0]}};
        ld = {{24{~c_uns & lb[7]}}, lb};
      end
      2'b01: begin
        be = c_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{c_wdata[15:0]}};
        ld = {{16{~c_uns & lh[15]}}, lh};
      end
      default: ;
    endcase
  end

  // Array write at commit; faulted stores and stores abandoned by reset never land.
  always_ff @(posedge clk) begin
    if (rst && commit && c_we && !c_err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  // Next-state and wait counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req_valid) begin
        cnt_nxt   = CW'(WAIT_CYCLES);
        state_nxt = (WAIT_CYCLES == 0) ? RESP : BUSY;
      end
      BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = RESP;
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request latch and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      l_we      <= 1'b0;
      l_addr    <= '0;
      l_wdata   <= '0;
      l_size    <= 2'b00;
      l_uns     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        l_we    <= req_we;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        l_size  <= req_size;
        l_uns   <= req_uns;
      end
      if (commit) begin
        rsp_err   <= c_err;
        rsp_rdata <= (c_err || c_we) ? '0 : ld;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-addressed reference model plus directed vectors,
// main instance with two wait states and a second zero-wait instance.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int W     = 2;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_uns, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;
  logic        z_valid, z_ready, z_rsp_valid, z_rsp_ready, z_err;
  logic [31:0] z_rdata;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_uns(req_uns),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_uns(req_uns),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rdata), .rsp_err(z_err));

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk_en = 0, m_busy = 0;
  int m_acc = 0;
  logic [31:0] m_rd = '0;
  logic        m_err = 1'b0;
  logic [7:0]  mm [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rdb(input int a);
    return mm.exists(a) ? mm[a] : 8'h00;
  endfunction

  function automatic logic m_fault(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdb(int'(a));
    h = {rdb(int'(a) + 1), rdb(int'(a))};
    case (sz)
      2'd0:    return u ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return u ? {16'h0, h} : {{16{h[15]}}, h};
      default: return {rdb(int'(a) + 3), rdb(int'(a) + 2), h};
    endcase
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mm[int'(a) + i] = d[8*i +: 8];
  endtask

  // Every cycle: handshake signals follow the model's timing; payload checked while valid.
  always @(negedge clk) begin : cmp
    logic ev;
    if (chk_en) begin
      ev = m_busy && (cyc - m_acc >= W);
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        chk("rsp_rdata", rsp_rdata, m_rd);
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  // Present one request to the main instance; returns at #1 after its accept edge.
  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic u, input bit commit);
    req_we = we; req_addr = a; req_wdata = d; req_size = sz; req_uns = u; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_err = m_fault(a, sz);
    m_rd  = (m_err || we) ? 32'h0 : m_load(a, sz, u);
    if (commit && we && !m_err) m_store(a, d, sz);
    m_acc  = cyc;
    m_busy = 1;
    // payload churn after accept must not reach the committed access
    req_addr = ~a; req_wdata = ~d; req_size = ~sz; req_we = ~we; req_uns = ~u;
  endtask

  // Wait (bounded) for the response, stall `hold` cycles, then take it.
  task automatic take(input int hold, output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1 within 40 cycles");
    end
    lat = cyc + 1 - m_acc;
    rd  = rsp_rdata;
    er  = rsp_err;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    m_busy = 0;
  endtask

  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic u, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    send(we, a, d, sz, u, 1);
    take(hold, rd, er, lat);
  endtask

  // Zero-wait instance: response must be visible in the very next cycle.
  task automatic zx(input logic we, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] sz, output logic [31:0] rd, output logic er,
                    output logic vld, output logic rdy);
    req_we = we; req_addr = a; req_wdata = d; req_size = sz; req_uns = 1'b0; z_valid = 1'b1;
    @(posedge clk); #1;
    z_valid = 1'b0;
    @(negedge clk);
    vld = z_rsp_valid; rdy = z_ready; rd = z_rdata; er = z_err;
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    z_rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er, vld, rdy;
    int          lat;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_size = '0; req_uns = 0;
    rsp_ready = 0; z_valid = 0; z_rsp_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_z_ready", 32'(z_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;

    // word round trip, three-edge latency
    xact(1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 0, rd, er, lat);
    chk("sw_latency", 32'(lat), 32'd3);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_rdata", rd, 32'h0);
    xact(0, 32'h10, 32'h0, 2'd2, 0, 0, rd, er, lat);
    chk("lw_latency", 32'(lat), 32'd3);
    chk("lw_rdata", rd, 32'hDEADBEEF);

    // byte store and sign/zero extension
    xact(1, 32'h11, 32'hFFFFFF80, 2'd0, 0, 0, rd, er, lat);
    xact(0, 32'h10, 32'h0, 2'd2, 0, 0, rd, er, lat);
    chk("lw_after_sb", rd, 32'hDEAD80EF);
    xact(0, 32'h11, 32'h0, 2'd0, 0, 0, rd, er, lat);
    chk("lb", rd, 32'hFFFFFF80);
    xact(0, 32'h11, 32'h0, 2'd0, 1, 0, rd, er, lat);
    chk("lbu", rd, 32'h00000080);
    xact(0, 32'h12, 32'h0, 2'd1, 0, 0, rd, er, lat);
    chk("lh_hi", rd, 32'hFFFFDEAD);
    xact(0, 32'h10, 32'h0, 2'd1, 1, 0, rd, er, lat);
    chk("lhu_lo", rd, 32'h000080EF);
    xact(1, 32'h12, 32'hFFFF1234, 2'd1, 0, 0, rd, er, lat);
    xact(0, 32'h10, 32'h0, 2'd2, 1, 0, rd, er, lat);
    chk("lw_after_sh", rd, 32'h123480EF);

    // misaligned accesses fault and leave memory alone
    xact(0, 32'h13, 32'h0, 2'd1, 0, 0, rd, er, lat);
    chk("lh_mis_err", 32'(er), 32'd1);
    chk("lh_mis_rdata", rd, 32'h0);
    xact(1, 32'h12, 32'h55555555, 2'd2, 0, 0, rd, er, lat);
    chk("sw_mis_err", 32'(er), 32'd1);
    xact(0, 32'h10, 32'h0, 2'd2, 0, 0, rd, er, lat);
    chk("lw_unchanged", rd, 32'h123480EF);

    // backpressure: five stalled cycles, checked every cycle by the compare process
    xact(0, 32'h10, 32'h0, 2'd0, 0, 5, rd, er, lat);
    chk("bp_rdata", rd, 32'hFFFFFFEF);

    // range and illegal size
    xact(0, 32'(4 * DEPTH), 32'h0, 2'd2, 0, 0, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'h0);
    xact(0, 32'h10, 32'h0, 2'd3, 0, 0, rd, er, lat);
    chk("size3_err", 32'(er), 32'd1);
    xact(1, 32'(4 * DEPTH - 4), 32'hA5A5C3C3, 2'd2, 0, 0, rd, er, lat);
    xact(0, 32'(4 * DEPTH - 4), 32'h0, 2'd2, 0, 0, rd, er, lat);
    chk("last_word", rd, 32'hA5A5C3C3);
    chk("last_word_err", 32'(er), 32'd0);

    // zero-wait instance
    zx(1, 32'h8, 32'h0BADF00D, 2'd2, rd, er, vld, rdy);
    chk("z_sw_valid", 32'(vld), 32'd1);
    chk("z_sw_ready", 32'(rdy), 32'd0);
    chk("z_sw_err", 32'(er), 32'd0);
    zx(0, 32'h8, 32'h0, 2'd2, rd, er, vld, rdy);
    chk("z_lw_valid", 32'(vld), 32'd1);
    chk("z_lw_rdata", rd, 32'h0BADF00D);
    zx(0, 32'(4 * DEPTH), 32'h0, 2'd2, rd, er, vld, rdy);
    chk("z_oor_err", 32'(er), 32'd1);
    chk("z_oor_rdata", rd, 32'h0);

    // reset while a store is waiting
    xact(1, 32'h20, 32'hCAFEF00D, 2'd2, 0, 0, rd, er, lat);
    xact(0, 32'h20, 32'h0, 2'd2, 0, 0, rd, er, lat);
    chk("pre_rst_lw", rd, 32'hCAFEF00D);
    send(1, 32'h20, 32'h12345678, 2'd2, 0, 0);
    @(negedge clk);
    chk_en = 0;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_err", 32'(rsp_err), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    m_busy = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;
    xact(0, 32'h20, 32'h0, 2'd2, 0, 0, rd, er, lat);
    chk("post_rst_lw", rd, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
